// File: rtl/ibex_icache_mem_pkg.sv
// ibex_icache_mem_pkg: shared entry type and address-region decode for the icache memory responder
package ibex_icache_mem_pkg;
  localparam logic [31:0] PmpBaseDef = 32'hFFFF_0000;
  localparam logic [31:0] PmpMaskDef = 32'hFFFF_0000;
  localparam logic [31:0] ErrBaseDef = 32'h8000_0000;
  localparam logic [31:0] ErrMaskDef = 32'hFFFF_F000;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  age;
  } mem_entry_t;
  function automatic logic pmp_hit(input logic [31:0] a, input logic [31:0] base = PmpBaseDef,
                                   input logic [31:0] mask = PmpMaskDef);
    return (a & mask) == base;
  endfunction
  function automatic logic err_hit(input logic [31:0] a, input logic [31:0] base = ErrBaseDef,
                                   input logic [31:0] mask = ErrMaskDef);
    return (a & mask) == base;
  endfunction
endpackage

// File: rtl/ibex_icache_mem_responder_if.sv
// ibex_icache_mem_responder_if: icache instruction-bus signals between fetch port and memory responder
interface ibex_icache_mem_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        stall;
  logic        gnt;
  logic        pmp_err;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  modport master (output req, addr, stall, input gnt, pmp_err, rvalid, rdata, err, busy);
  modport slave (input req, addr, stall, output gnt, pmp_err, rvalid, rdata, err, busy);
endinterface

// File: rtl/ibex_icache_mem_resp_fifo.sv
// ibex_icache_mem_resp_fifo: in-order outstanding-request FIFO whose entries age every cycle
module ibex_icache_mem_resp_fifo
  import ibex_icache_mem_pkg::*;
#(
  parameter int unsigned Depth  = 4,
  parameter logic [3:0]  MaxAge = 4'd2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  mem_entry_t               wdata,
  output mem_entry_t               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);
  localparam int unsigned Aw = $clog2(Depth);
  mem_entry_t mem [Depth];
  logic [Aw-1:0] wptr, rptr;
  assign head  = mem[rptr];
  assign full  = count == (Aw+1)'(Depth);
  assign empty = count == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < int'(Depth); i++)
        mem[i].age <= (mem[i].age >= MaxAge) ? MaxAge : mem[i].age + 4'd1;
      if (push) mem[wptr] <= wdata;
      wptr  <= push ? wptr + Aw'(1) : wptr;
      rptr  <= pop ? rptr + Aw'(1) : rptr;
      count <= count + (Aw+1)'(push) - (Aw+1)'(pop);
    end
  end
endmodule

// File: rtl/ibex_icache_mem_responder.sv
// ibex_icache_mem_responder: grants icache fetches and returns addr^seed data in order after a fixed latency
module ibex_icache_mem_responder
  import ibex_icache_mem_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned RespLatency    = 2,
  parameter logic [31:0] DataSeed       = 32'hDEAD_BEEF,
  parameter logic [31:0] PmpBase        = PmpBaseDef,
  parameter logic [31:0] PmpMask        = PmpMaskDef,
  parameter logic [31:0] ErrBase        = ErrBaseDef,
  parameter logic [31:0] ErrMask        = ErrMaskDef
) (
  input logic                        clk,
  input logic                        rst,
  ibex_icache_mem_responder_if.slave bus
);
  localparam int unsigned Aw = $clog2(MaxOutstanding);
  mem_entry_t head;
  logic full, empty, push, pop;
  logic [Aw:0] count;
  assign bus.pmp_err = bus.req & pmp_hit(bus.addr, PmpBase, PmpMask);
  assign push        = bus.req & ~bus.pmp_err & ~bus.stall & ~full & ~rst;
  assign bus.gnt     = push;
  // Entry is pushed with age 0, so age L-1 is reached one edge before the grant is L edges old
  assign pop         = ~empty & (head.age >= 4'(RespLatency - 1));
  assign bus.busy    = (count != '0) | bus.rvalid;
  ibex_icache_mem_resp_fifo #(
    .Depth (MaxOutstanding),
    .MaxAge(4'(RespLatency))
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata('{addr: {bus.addr[31:2], 2'b00}, age: 4'd0}),
    .head (head),
    .full (full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.err    <= 1'b0;
    end else begin
      bus.rvalid <= pop;
      bus.rdata  <= pop ? head.addr ^ DataSeed : '0;
      bus.err    <= pop & err_hit(head.addr, ErrBase, ErrMask);
    end
  end
endmodule
